// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: runs one complete SD-card SPI transaction per request on top of the
// `sd` byte engine (80-clock init, command frame, R1 poll, optional 4-byte trailer
// or 512-byte block read into an external buffer).
//
// Ports
//   clock50, reset_n          : 50 MHz clock, asynchronous active-low reset
//   start, op, cmd_index,
//   cmd_arg, cmd_crc          : transaction request (op 0 INIT, 1 CMD+R1,
//                               2 CMD+R1+block read, 3 CMD+R1+4 trailer bytes)
//   busy, done, r1, resp, err : transaction status and results
//   buf_we, buf_addr, buf_data: block-read buffer write port
//   sd_signal, sd_cmd, sd_out : command interface to `sd`
//   sd_din, sd_busy           : result and status from `sd`
module sd_cmd_seq #(
    parameter int unsigned R1_POLL_MAX    = 8,
    parameter int unsigned TOKEN_POLL_MAX = 4096,
    parameter int unsigned BUSY_WAIT      = 8
) (
    input  logic        clock50,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [7:0]  cmd_crc,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic [31:0] resp,
    output logic [2:0]  err,
    output logic        buf_we,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_data,
    output logic        sd_signal,
    output logic [1:0]  sd_cmd,
    output logic [7:0]  sd_out,
    input  logic [7:0]  sd_din,
    input  logic        sd_busy
);

    localparam int unsigned CntMax0 = (TOKEN_POLL_MAX > 512) ? TOKEN_POLL_MAX : 512;
    localparam int unsigned CntMax  = (R1_POLL_MAX > CntMax0) ? R1_POLL_MAX : CntMax0;
    localparam int unsigned CntW    = $clog2(CntMax);
    localparam int unsigned WaitW   = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    localparam logic [2:0] ErrOk       = 3'd0;
    localparam logic [2:0] ErrR1Tmo    = 3'd1;
    localparam logic [2:0] ErrR1Bad    = 3'd2;
    localparam logic [2:0] ErrBadTok   = 3'd3;
    localparam logic [2:0] ErrTokTmo   = 3'd4;
    localparam logic [2:0] ErrNoEngine = 3'd5;

    localparam logic [1:0] CmdInit = 2'd0;
    localparam logic [1:0] CmdXfer = 2'd1;
    localparam logic [1:0] CmdCsLo = 2'd2;
    localparam logic [1:0] CmdCsHi = 2'd3;

    // Engine-call handshake; StResult is the clock after sd_busy falls.
    typedef enum logic [2:0] {
        StIdle, StIssue, StWaitHi, StWaitLo, StResult, StDone
    } state_e;

    // Which step of the transaction the current engine call belongs to.
    typedef enum logic [3:0] {
        PhInit, PhCsLo, PhPre, PhFrame, PhR1Poll, PhResp,
        PhToken, PhData, PhCrc, PhPost, PhCsHi
    } phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [1:0]        op_q, op_d;
    logic [5:0]        idx_q, idx_d;
    logic [31:0]       arg_q, arg_d;
    logic [7:0]        crc_q, crc_d;
    logic [7:0]        r1_q, r1_d;
    logic [31:0]       resp_q, resp_d;
    logic [2:0]        err_q, err_d;
    logic              buf_we_q, buf_we_d;
    logic [8:0]        buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            phase_q    <= PhInit;
            cnt_q      <= '0;
            wait_q     <= '0;
            op_q       <= 2'd0;
            idx_q      <= 6'd0;
            arg_q      <= 32'd0;
            crc_q      <= 8'd0;
            r1_q       <= 8'hFF;
            resp_q     <= 32'd0;
            err_q      <= ErrOk;
            buf_we_q   <= 1'b0;
            buf_addr_q <= 9'd0;
            buf_data_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            crc_q      <= crc_d;
            r1_q       <= r1_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        op_d       = op_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        crc_d      = crc_q;
        r1_d       = r1_q;
        resp_d     = resp_q;
        err_d      = err_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;

        // Address advances in the clock after each write strobe.
        if (buf_we_q) begin
            buf_addr_d = buf_addr_q + 9'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start && !sd_busy) begin
                    op_d       = op;
                    idx_d      = cmd_index;
                    arg_d      = cmd_arg;
                    crc_d      = cmd_crc;
                    err_d      = ErrOk;
                    buf_addr_d = 9'd0;
                    cnt_d      = '0;
                    phase_d    = (op == 2'd0) ? PhInit : PhCsLo;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                wait_d  = '0;
                state_d = StWaitHi;
            end
            StWaitHi: begin
                if (sd_busy) begin
                    state_d = StWaitLo;
                end else if (wait_q == WaitW'(BUSY_WAIT - 1)) begin
                    // Engine never answered: skip POST/CS_HI, nothing to talk to.
                    err_d   = ErrNoEngine;
                    state_d = StDone;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWaitLo: begin
                if (!sd_busy) begin
                    state_d = StResult;
                end
            end
            StResult: begin
                state_d = StIssue;
                case (phase_q)
                    PhInit: state_d = StDone;
                    PhCsLo: phase_d = PhPre;
                    PhPre: begin
                        phase_d = PhFrame;
                        cnt_d   = '0;
                    end
                    PhFrame: begin
                        if (cnt_q == CntW'(5)) begin
                            phase_d = PhR1Poll;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    PhR1Poll: begin
                        if (!sd_din[7]) begin
                            r1_d  = sd_din;
                            cnt_d = '0;
                            unique case (op_q)
                                2'd3: phase_d = PhResp;
                                2'd2: begin
                                    if (sd_din != 8'h00) begin
                                        err_d   = ErrR1Bad;
                                        phase_d = PhPost;
                                    end else begin
                                        phase_d = PhToken;
                                    end
                                end
                                default: phase_d = PhPost;
                            endcase
                        end else if (cnt_q == CntW'(R1_POLL_MAX - 1)) begin
                            err_d   = ErrR1Tmo;
                            phase_d = PhPost;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    PhResp: begin
                        resp_d = {resp_q[23:0], sd_din};
                        if (cnt_q == CntW'(3)) begin
                            phase_d = PhPost;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    PhToken: begin
                        if (sd_din == 8'hFE) begin
                            phase_d = PhData;
                            cnt_d   = '0;
                        end else if (sd_din == 8'hFF) begin
                            if (cnt_q == CntW'(TOKEN_POLL_MAX - 1)) begin
                                err_d   = ErrTokTmo;
                                phase_d = PhPost;
                            end else begin
                                cnt_d = cnt_q + CntW'(1);
                            end
                        end else begin
                            err_d   = ErrBadTok;
                            phase_d = PhPost;
                        end
                    end
                    PhData: begin
                        buf_we_d   = 1'b1;
                        buf_data_d = sd_din;
                        if (cnt_q == CntW'(511)) begin
                            phase_d = PhCrc;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    PhCrc: begin
                        if (cnt_q == CntW'(1)) begin
                            phase_d = PhPost;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    PhPost: phase_d = PhCsHi;
                    PhCsHi: state_d = StDone;
                    default: state_d = StDone;
                endcase
            end
            StDone: begin
                state_d = StIdle;
                phase_d = PhInit;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sd_signal = (state_q == StIssue);
        busy      = (state_q != StIdle) && (state_q != StDone);
        done      = (state_q == StDone);
        r1        = r1_q;
        resp      = resp_q;
        err       = err_q;
        buf_we    = buf_we_q;
        buf_addr  = buf_addr_q;
        buf_data  = buf_data_q;

        case (phase_q)
            PhInit:  sd_cmd = CmdInit;
            PhCsLo:  sd_cmd = CmdCsLo;
            PhCsHi:  sd_cmd = CmdCsHi;
            default: sd_cmd = CmdXfer;
        endcase

        sd_out = 8'hFF;
        if (phase_q == PhFrame) begin
            case (cnt_q[2:0])
                3'd0:    sd_out = {2'b01, idx_q};
                3'd1:    sd_out = arg_q[31:24];
                3'd2:    sd_out = arg_q[23:16];
                3'd3:    sd_out = arg_q[15:8];
                3'd4:    sd_out = arg_q[7:0];
                3'd5:    sd_out = crc_q;
                default: sd_out = 8'hFF;
            endcase
        end
    end

endmodule
